// File: rtl/id_ex_buf_if.sv
// Decode-to-execute handshake bundle: decode push side and execute pop side.
// The buffer uses the slave modport; the stage driving decode/execute uses master.
interface id_ex_buf_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:1]   in_pc;
  logic [4:0]        in_rd_addr;
  logic              in_rd_en;
  logic              in_illegal;
  logic [CTRL_W-1:0] in_ctrl;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:1]   out_pc;
  logic [4:0]        out_rd_addr;
  logic              out_rd_en;
  logic              out_illegal;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_pc, in_rd_addr, in_rd_en, in_illegal, in_ctrl, out_ready,
    input  in_ready, out_valid, out_pc, out_rd_addr, out_rd_en, out_illegal, out_ctrl
  );

  modport slave (
    input  in_valid, in_pc, in_rd_addr, in_rd_en, in_illegal, in_ctrl, out_ready,
    output in_ready, out_valid, out_pc, out_rd_addr, out_rd_en, out_illegal, out_ctrl
  );
endinterface

// File: rtl/id_ex_buf.sv
// Decode-to-execute FIFO buffer, latency 1 (no bypass); in_ready depends only on occupancy.
// Flush empties the buffer; tracks sticky illegal-issue flag and saturating stall count.
module id_ex_buf #(
  parameter int DEPTH   = 2,
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 32,
  parameter int STALL_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  id_ex_buf_if.slave                   bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         illegal_seen,
  output logic [STALL_W-1:0]           stall_cnt
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:1]   pc;
    logic [4:0]        rd_addr;
    logic              rd_en;
    logic              illegal;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             wr_entry;
  entry_t             head;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               illegal_seen_q, illegal_seen_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               empty;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty         = (count_q == '0);
  assign bus.in_ready  = (count_q < FULL_CNT);
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid && bus.in_ready && !flush;
  assign pop           = bus.out_valid && bus.out_ready && !flush;

  // Illegal instructions must never write back, whatever the decoder claimed.
  always_comb begin
    wr_entry         = '0;
    wr_entry.pc      = bus.in_pc;
    wr_entry.rd_addr = bus.in_rd_addr;
    wr_entry.rd_en   = bus.in_rd_en && !bus.in_illegal;
    wr_entry.illegal = bus.in_illegal;
    wr_entry.ctrl    = bus.in_ctrl;
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.out_pc      = empty ? '0 : head.pc;
  assign bus.out_rd_addr = empty ? '0 : head.rd_addr;
  assign bus.out_rd_en   = empty ? 1'b0 : head.rd_en;
  assign bus.out_illegal = empty ? 1'b0 : head.illegal;
  assign bus.out_ctrl    = empty ? '0 : head.ctrl;

  always_comb begin
    count_d        = count_q;
    wr_ptr_d       = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d       = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    illegal_seen_d = illegal_seen_q || (pop && head.illegal);
    stall_d        = stall_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      count_d        = '0;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      illegal_seen_d = 1'b0;
    end
    // Stall history survives flush; only reset clears it.
    if (bus.out_valid && !bus.out_ready && !flush && (stall_q != '1))
      stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      illegal_seen_q <= 1'b0;
      stall_q        <= '0;
    end else begin
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      illegal_seen_q <= illegal_seen_d;
      stall_q        <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= wr_entry;
  end

  assign count        = count_q;
  assign illegal_seen = illegal_seen_q;
  assign stall_cnt    = stall_q;
endmodule

// File: tb/tb_id_ex_buf.sv
// Directed bench for id_ex_buf: DEPTH=2 vector table plus DEPTH=3 and DEPTH=1 sequences.
module tb_id_ex_buf;
  logic clk;
  logic rst_n;
  logic flush2, flush3, flush1;
  logic [1:0]  c2;
  logic [1:0]  c3;
  logic [0:0]  c1;
  logic        seen2, seen3, seen1;
  logic [15:0] stall2;
  logic [3:0]  stall3;
  logic [15:0] stall1;
  int checks = 0;
  int failures = 0;

  id_ex_buf_if #(.XLEN(32), .CTRL_W(32)) bus2 ();
  id_ex_buf_if #(.XLEN(32), .CTRL_W(32)) bus3 ();
  id_ex_buf_if #(.XLEN(32), .CTRL_W(32)) bus1 ();

  id_ex_buf #(.DEPTH(2), .XLEN(32), .CTRL_W(32), .STALL_W(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .bus(bus2),
    .count(c2), .illegal_seen(seen2), .stall_cnt(stall2));
  id_ex_buf #(.DEPTH(3), .XLEN(32), .CTRL_W(32), .STALL_W(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3), .bus(bus3),
    .count(c3), .illegal_seen(seen3), .stall_cnt(stall3));
  id_ex_buf #(.DEPTH(1), .XLEN(32), .CTRL_W(32), .STALL_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .bus(bus1),
    .count(c1), .illegal_seen(seen1), .stall_cnt(stall1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        en;
    logic        ill;
    logic [31:0] ctrl;
    logic        ordy;
    logic        fl;
    logic [1:0]  e_cnt;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [4:0]  e_rd;
    logic        e_en;
    logic        e_ill;
    logic [31:0] e_ctrl;
    logic        e_seen;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    vecs[0]  = '{1, 32'h100, 5, 1, 0, 32'h11, 0, 0,  2'd1, 1, 1, 32'h100, 5, 1, 0, 32'h11, 0, 16'd0};
    vecs[1]  = '{1, 32'h104, 6, 1, 0, 32'h22, 0, 0,  2'd2, 0, 1, 32'h100, 5, 1, 0, 32'h11, 0, 16'd1};
    vecs[2]  = '{1, 32'h108, 7, 1, 0, 32'h99, 0, 0,  2'd2, 0, 1, 32'h100, 5, 1, 0, 32'h11, 0, 16'd2};
    vecs[3]  = '{1, 32'h10C, 7, 1, 0, 32'h98, 1, 0,  2'd1, 1, 1, 32'h104, 6, 1, 0, 32'h22, 0, 16'd2};
    vecs[4]  = '{1, 32'h110, 5, 1, 1, 32'h33, 1, 0,  2'd1, 1, 1, 32'h110, 5, 0, 1, 32'h33, 0, 16'd2};
    vecs[5]  = '{0, 32'h0,   0, 0, 0, 32'h0,  1, 0,  2'd0, 1, 0, 32'h0,   0, 0, 0, 32'h0,  1, 16'd2};
    vecs[6]  = '{0, 32'h0,   0, 0, 0, 32'h0,  0, 0,  2'd0, 1, 0, 32'h0,   0, 0, 0, 32'h0,  1, 16'd2};
    vecs[7]  = '{1, 32'h200, 8, 1, 0, 32'h44, 0, 0,  2'd1, 1, 1, 32'h200, 8, 1, 0, 32'h44, 1, 16'd2};
    vecs[8]  = '{1, 32'h204, 9, 0, 0, 32'h55, 0, 0,  2'd2, 0, 1, 32'h200, 8, 1, 0, 32'h44, 1, 16'd3};
    vecs[9]  = '{1, 32'h208, 10, 1, 0, 32'h77, 0, 1, 2'd0, 1, 0, 32'h0,   0, 0, 0, 32'h0,  0, 16'd3};
    vecs[10] = '{1, 32'h300, 11, 1, 0, 32'h66, 0, 0, 2'd1, 1, 1, 32'h300, 11, 1, 0, 32'h66, 0, 16'd3};
    vecs[11] = '{0, 32'h0,   0, 0, 0, 32'h0,  1, 0,  2'd0, 1, 0, 32'h0,   0, 0, 0, 32'h0,  0, 16'd3};

    rst_n = 1'b0;
    flush2 = 1'b0; flush3 = 1'b0; flush1 = 1'b0;
    bus2.in_valid = 0; bus2.in_pc = '0; bus2.in_rd_addr = '0; bus2.in_rd_en = 0;
    bus2.in_illegal = 0; bus2.in_ctrl = '0; bus2.out_ready = 0;
    bus3.in_valid = 0; bus3.in_pc = '0; bus3.in_rd_addr = '0; bus3.in_rd_en = 0;
    bus3.in_illegal = 0; bus3.in_ctrl = '0; bus3.out_ready = 0;
    bus1.in_valid = 0; bus1.in_pc = '0; bus1.in_rd_addr = '0; bus1.in_rd_en = 0;
    bus1.in_illegal = 0; bus1.in_ctrl = '0; bus1.out_ready = 0;

    #3;
    check("rst_count", c2, 0);
    check("rst_in_ready", bus2.in_ready, 1);
    check("rst_out_valid", bus2.out_valid, 0);
    check("rst_seen", seen2, 0);
    check("rst_stall", stall2, 0);
    check("rst_out_pc", bus2.out_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // DEPTH=2 vector table: inputs applied for one edge, outputs checked after it.
    for (int i = 0; i < 12; i++) begin
      bus2.in_valid   = vecs[i].iv;
      bus2.in_pc      = vecs[i].pc[31:1];
      bus2.in_rd_addr = vecs[i].rd;
      bus2.in_rd_en   = vecs[i].en;
      bus2.in_illegal = vecs[i].ill;
      bus2.in_ctrl    = vecs[i].ctrl;
      bus2.out_ready  = vecs[i].ordy;
      flush2          = vecs[i].fl;
      @(negedge clk);
      check($sformatf("v%0d_count", i), c2, vecs[i].e_cnt);
      check($sformatf("v%0d_in_ready", i), bus2.in_ready, vecs[i].e_irdy);
      check($sformatf("v%0d_out_valid", i), bus2.out_valid, vecs[i].e_ov);
      check($sformatf("v%0d_out_pc", i), {bus2.out_pc, 1'b0}, vecs[i].e_pc);
      check($sformatf("v%0d_out_rd_addr", i), bus2.out_rd_addr, vecs[i].e_rd);
      check($sformatf("v%0d_out_rd_en", i), bus2.out_rd_en, vecs[i].e_en);
      check($sformatf("v%0d_out_illegal", i), bus2.out_illegal, vecs[i].e_ill);
      check($sformatf("v%0d_out_ctrl", i), bus2.out_ctrl, vecs[i].e_ctrl);
      check($sformatf("v%0d_illegal_seen", i), seen2, vecs[i].e_seen);
      check($sformatf("v%0d_stall_cnt", i), stall2, vecs[i].e_stall);
    end
    bus2.in_valid = 0; bus2.out_ready = 0; flush2 = 0;

    // DEPTH=3: one resident entry, then five push+pop cycles crossing the wrap.
    bus3.in_valid = 1; bus3.in_pc = 31'(32'hA0 >> 1); bus3.out_ready = 0;
    @(negedge clk);
    check("d3_prime_count", c3, 1);
    check("d3_prime_pc", {bus3.out_pc, 1'b0}, 32'hA0);
    for (int k = 1; k <= 5; k++) begin
      bus3.in_valid = 1; bus3.in_pc = 31'((32'hA0 + 4 * k) >> 1); bus3.out_ready = 1;
      @(negedge clk);
      check($sformatf("d3_pp%0d_count", k), c3, 1);
      check($sformatf("d3_pp%0d_pc", k), {bus3.out_pc, 1'b0}, 32'hA0 + 4 * k);
    end
    bus3.in_valid = 0; bus3.out_ready = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("d3_stall%0d", i), stall3, (i + 1 > 15) ? 15 : i + 1);
    end
    bus3.in_valid = 1; bus3.in_pc = 31'(32'hC0 >> 1);
    @(negedge clk);
    bus3.in_pc = 31'(32'hC4 >> 1);
    @(negedge clk);
    bus3.in_valid = 0;
    check("d3_full_count", c3, 3);
    check("d3_full_in_ready", bus3.in_ready, 0);
    check("d3_full_head", {bus3.out_pc, 1'b0}, 32'hB4);
    check("d3_stall_hold", stall3, 15);

    // DEPTH=1: full stage refuses a push even while it is being popped.
    bus1.in_valid = 1; bus1.in_pc = 31'(32'hD0 >> 1); bus1.out_ready = 0;
    @(negedge clk);
    check("d1_count_full", c1, 1);
    check("d1_in_ready_full", bus1.in_ready, 0);
    bus1.in_pc = 31'(32'hD4 >> 1); bus1.out_ready = 1;
    @(negedge clk);
    check("d1_pop_count", c1, 0);
    check("d1_pop_valid", bus1.out_valid, 0);
    bus1.out_ready = 0;
    @(negedge clk);
    check("d1_repush_pc", {bus1.out_pc, 1'b0}, 32'hD4);
    check("d1_repush_count", c1, 1);
    bus1.in_valid = 0; bus1.out_ready = 1;
    @(negedge clk);
    check("d1_drain_count", c1, 0);
    bus1.out_ready = 0;

    // Asynchronous reset while DEPTH=2 holds two entries and a stall history.
    bus2.in_valid = 1; bus2.in_pc = 31'(32'h400 >> 1); bus2.in_ctrl = 32'h1;
    @(negedge clk);
    bus2.in_pc = 31'(32'h404 >> 1);
    @(negedge clk);
    bus2.in_valid = 0;
    check("ar_pre_count", c2, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count", c2, 0);
    check("ar_out_valid", bus2.out_valid, 0);
    check("ar_in_ready", bus2.in_ready, 1);
    check("ar_out_pc", bus2.out_pc, 0);
    check("ar_out_ctrl", bus2.out_ctrl, 0);
    check("ar_stall", stall2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus2.in_valid = 1; bus2.in_pc = 31'(32'h500 >> 1); bus2.in_ctrl = 32'hDEADBEEF;
    #1;
    check("ar_no_bypass", bus2.out_valid, 0);
    @(negedge clk);
    bus2.in_valid = 0;
    check("ar_first_ctrl", bus2.out_ctrl, 32'hDEADBEEF);
    check("ar_first_count", c2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_buf.md
ID_EX_BUF -- requirements
Module: id_ex_buf

Interface
REQ-001 Parameter DEPTH, default 2, number of decode-to-execute buffer entries; legal range 1..8, not restricted to powers of two.
REQ-002 Parameter XLEN, default 32, architectural PC/data width.
REQ-003 Parameter CTRL_W, default 32, width of the packed decoded control bundle (imm, alu/lsu/br ops, flags).
REQ-004 Parameter STALL_W, default 16, stall counter width.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 flush  in  1  synchronous pipeline flush from execute/branch resolution.
REQ-008 in_valid  in  1  decode stage presents an instruction.
REQ-009 in_ready  out  1  buffer can accept an instruction.
REQ-010 in_pc  in  XLEN-1 (bits XLEN-1:1)  instruction PC, halfword aligned.
REQ-011 in_rd_addr  in  5  destination register.
REQ-012 in_rd_en  in  1  destination write enable.
REQ-013 in_illegal  in  1  decoder flagged illegal instruction.
REQ-014 in_ctrl  in  CTRL_W  decoded control bundle.
REQ-015 out_valid  out  1  head entry available to execute.
REQ-016 out_ready  in  1  execute stage accepts head entry.
REQ-017 out_pc, out_rd_addr, out_rd_en, out_illegal, out_ctrl  out  widths as inputs  head entry fields.
REQ-018 count  out  $clog2(DEPTH+1)  number of occupied entries.
REQ-019 illegal_seen  out  1  sticky: an illegal instruction has been issued to execute.
REQ-020 stall_cnt  out  STALL_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-021 Push occurs when in_valid=1 and in_ready=1 and flush=0; pop occurs when out_valid=1 and out_ready=1 and flush=0.
REQ-022 in_ready shall equal (count < DEPTH), derived from registered state only; no combinational path from out_ready to in_ready.
REQ-023 out_valid shall equal (count != 0); outputs come from storage, so a pushed entry is first visible on out_* the cycle after the push (latency 1, no bypass even when empty).
REQ-024 When count=0, out_pc, out_rd_addr, out_rd_en, out_illegal and out_ctrl shall all be driven 0.
REQ-025 Entries leave in push order (FIFO); read and write pointers wrap from DEPTH-1 to 0.
REQ-026 Push with pop in the same cycle leaves count unchanged and advances both pointers.
REQ-027 When full, in_ready=0 and no push occurs even if a pop happens that cycle.
REQ-028 An entry pushed with in_illegal=1 shall be stored with rd_en forced to 0, regardless of in_rd_en.
REQ-029 flush has priority: next cycle count=0, pointers=0, illegal_seen=0. Any push or pop handshake in the flush cycle is discarded.
REQ-030 illegal_seen shall set on the cycle after a pop of an entry with illegal=1 and hold until flush or reset.
REQ-031 stall_cnt increments by 1 each cycle with out_valid=1, out_ready=0 and flush=0, saturates at all-ones, and is not cleared by flush.
REQ-032 With DEPTH=1, the block shall behave as a single registered stage that accepts a new push only when empty.

Reset
REQ-033 During rst_n=0, immediately and asynchronously: count=0, pointers=0, out_valid=0, in_ready=1, illegal_seen=0, stall_cnt=0, out_* payload=0; storage contents need not be reset.
REQ-034 Reset asserted mid-operation discards all entries; the first push after deassertion appears at out one cycle later.

Verification
REQ-035 DEPTH=2, push pc=0x100 then 0x104, out_ready=0 -> count=2, in_ready=0, out_pc=0x100, stall_cnt increments each cycle.
REQ-036 DEPTH=3, with count=1, drive a simultaneous push and pop for 5 cycles -> count stays 1, out_pc sequence is in push order, and the pointer wrap is exercised.
REQ-037 Push in_illegal=1, in_rd_en=1, rd_addr=5 -> out_rd_en=0, out_illegal=1; after pop, illegal_seen=1 until flush.
REQ-038 count=2 and flush=1 with concurrent in_valid=1 -> next cycle count=0, out_valid=0, out_* payload=0, pushed entry lost, illegal_seen=0.
REQ-039 Assert rst_n=0 asynchronously with count=2 -> outputs reset immediately; after release, push ctrl=0xDEADBEEF -> out_ctrl=0xDEADBEEF one cycle later.
REQ-040 STALL_W=4, hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt saturates at 15.
